// File: rtl/bp_me_lce_cmd_wormhole_scheduler.sv
// Round-robin shares one LCE command link among num_req_p encoded wormhole packets, serialized into flits.
// Latency: first flit one cycle after source handshake; a packet takes len+1 accepted link cycles, back-to-back with no bubble.
// Backpressure: link_ready_and_i stalls holding link_data_o; grant is held until the last flit is accepted.
module bp_me_lce_cmd_wormhole_scheduler #(
    parameter int num_req_p         = 2,
    parameter int flit_width_p      = 64,
    parameter int wh_header_width_p = 128,
    parameter int data_width_p      = 512,
    parameter int len_width_p       = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_req_p*wh_header_width_p-1:0] req_header_i,
    input  logic [num_req_p*data_width_p-1:0]      req_data_i,
    input  logic [num_req_p*len_width_p-1:0]       req_len_i,
    input  logic [num_req_p-1:0]                   req_v_i,
    output logic [num_req_p-1:0]                   req_ready_and_o,
    output logic [flit_width_p-1:0]                link_data_o,
    output logic                                   link_v_o,
    input  logic                                   link_ready_and_i,
    output logic                                   busy_o
);

    localparam int packet_width_lp = wh_header_width_p + data_width_p;
    localparam int max_flits_lp    = (packet_width_lp + flit_width_p - 1) / flit_width_p;
    localparam int max_len_lp      = max_flits_lp - 1;
    localparam int buf_width_lp    = max_flits_lp * flit_width_p;
    localparam int ptr_width_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    localparam logic [len_width_p-1:0]  max_len_c  = len_width_p'(max_len_lp);
    localparam logic [ptr_width_lp-1:0] ptr_init_c = ptr_width_lp'(num_req_p - 1);

    typedef enum logic {
        e_ready,
        e_send
    } state_e;

    state_e                                     state_r, state_n;
    logic [ptr_width_lp-1:0]                    ptr_r;
    logic [len_width_p-1:0]                     cnt_r;
    logic [len_width_p-1:0]                     len_r;
    logic [max_flits_lp-1:0][flit_width_p-1:0]  pkt_r;

    logic                          grant_found;
    logic [ptr_width_lp-1:0]       winner;
    logic                          arb_en;
    logic                          handshake;
    logic                          last_accept;
    logic [wh_header_width_p-1:0]  sel_header;
    logic [data_width_p-1:0]       sel_data;
    logic [len_width_p-1:0]        sel_len;
    int                            idx;

    // Search begins one past the last winner so every valid source gets its turn.
    always_comb begin
        grant_found = 1'b0;
        winner      = '0;
        idx         = 0;
        for (int i = 1; i <= num_req_p; i++) begin
            idx = (int'(ptr_r) + i) % num_req_p;
            if (!grant_found && req_v_i[idx]) begin
                grant_found = 1'b1;
                winner      = ptr_width_lp'(idx);
            end
        end
    end

    assign sel_header = req_header_i[winner*wh_header_width_p +: wh_header_width_p];
    assign sel_data   = req_data_i[winner*data_width_p +: data_width_p];
    assign sel_len    = req_len_i[winner*len_width_p +: len_width_p];

    assign link_v_o    = (state_r == e_send);
    assign busy_o      = (state_r == e_send);
    assign link_data_o = pkt_r[cnt_r];
    assign last_accept = (state_r == e_send) && link_ready_and_i && (cnt_r == len_r);

    // Arbitrating during the last accepted flit lets the next packet follow without a bubble.
    assign arb_en          = reset_n_i && ((state_r == e_ready) || last_accept);
    assign req_ready_and_o = (arb_en && grant_found) ? (num_req_p'(1) << winner) : '0;
    assign handshake       = |(req_v_i & req_ready_and_o);

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_ready: if (handshake) state_n = e_send;
            e_send:  if (last_accept) state_n = handshake ? e_send : e_ready;
            default: state_n = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_ready;
        end else begin
            state_r <= state_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r <= ptr_init_c;
            cnt_r <= '0;
            len_r <= '0;
            pkt_r <= '0;
        end else if (handshake) begin
            ptr_r <= winner;
            cnt_r <= '0;
            len_r <= (sel_len > max_len_c) ? max_len_c : sel_len;
            pkt_r <= buf_width_lp'({sel_data, sel_header});
        end else if ((state_r == e_send) && link_ready_and_i && (cnt_r != len_r)) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // Oversized lengths are clipped above, but they indicate an encoder bug.
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        handshake |-> (sel_len <= max_len_c));

endmodule

// File: tb/tb_bp_me_lce_cmd_wormhole_scheduler.sv
// Directed bench for the LCE command wormhole scheduler: single, full, back-to-back,
// backpressured, fairness and mid-packet reset scenarios against hand-computed flits.
module tb_bp_me_lce_cmd_wormhole_scheduler;

    localparam int NR = 2;
    localparam int FW = 64;
    localparam int HW = 128;
    localparam int DW = 512;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR*HW-1:0]  req_header;
    logic [NR*DW-1:0]  req_data;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     req_v;
    logic [NR-1:0]     req_ready;
    logic [FW-1:0]     link_data;
    logic              link_v;
    logic              link_rdy;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [127:0] h_a = 128'hA5A5_0101_0202_0303_A5A5_0404_0505_0606;
    logic [127:0] h_b = 128'hB6B6_1111_2222_3333_B6B6_4444_5555_6666;
    logic [127:0] h_c = 128'hC7C7_7777_8888_9999_C7C7_AAAA_BBBB_CCCC;
    logic [127:0] h_d = 128'hD8D8_1234_5678_9ABC_D8D8_DEF0_0FED_CBA9;
    logic [511:0] dat;
    logic [511:0] zero_dat = '0;

    always #5 clk = ~clk;

    bp_me_lce_cmd_wormhole_scheduler #(
        .num_req_p(NR), .flit_width_p(FW), .wh_header_width_p(HW),
        .data_width_p(DW), .len_width_p(LW)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .req_header_i(req_header),
        .req_data_i(req_data),
        .req_len_i(req_len),
        .req_v_i(req_v),
        .req_ready_and_o(req_ready),
        .link_data_o(link_data),
        .link_v_o(link_v),
        .link_ready_and_i(link_rdy),
        .busy_o(busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [127:0] h, input logic [511:0] d, input logic [3:0] l);
        req_header[s*HW +: HW] = h;
        req_data[s*DW +: DW]   = d;
        req_len[s*LW +: LW]    = l;
    endtask

    initial begin
        int bc;
        int c;
        int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        logic [1:0]  exp_rdy;
        logic [63:0] exp_flit;
        logic [127:0] hx;

        reset_n    = 1'b0;
        req_v      = '0;
        link_rdy   = 1'b1;
        req_header = '0;
        req_data   = '0;
        req_len    = '0;
        for (int i = 0; i < 8; i++) dat[i*64 +: 64] = 64'hDA7A_0000_0000_0000 | 64'(i + 1);

        // Reset state, even with sources requesting
        #1;
        req_v = 2'b11;
        #1;
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_link_v", link_v, 0);
        check_eq("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        req_v   = '0;
        reset_n = 1'b1;
        cyc();

        // Single short packet from source 0
        set_src(0, h_a, zero_dat, 4'd1);
        req_v = 2'b01;
        #1;
        check_eq("t1_grant", req_ready, 2'b01);
        cyc();
        req_v = '0;
        #1;
        check_eq("t1_link_v", link_v, 1);
        check_eq("t1_flit0", link_data, h_a[63:0]);
        cyc();
        check_eq("t1_flit1", link_data, h_a[127:64]);
        cyc();
        check_eq("t1_idle_v", link_v, 0);
        check_eq("t1_idle_busy", busy, 0);
        req_v = 2'b01;
        #1;
        check_eq("t1_ready_back", req_ready, 2'b01);
        req_v = '0;
        #1;

        // Full 10-flit data packet with the link always ready
        set_src(0, h_b, dat, 4'd9);
        req_v = 2'b01;
        #1;
        cyc();
        req_v = '0;
        bc = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (busy) bc++;
            if (k < 2) check_eq("t2_hdr", link_data, h_b[k*64 +: 64]);
            else if (k < 10) check_eq("t2_data", link_data, dat[(k-2)*64 +: 64]);
            cyc();
        end
        check_eq("t2_busy_cycles", bc, 10);

        // Fairness: source 1 granted alone, then both valid -> source 0 first
        set_src(1, h_c, zero_dat, 4'd0);
        req_v = 2'b10;
        #1;
        check_eq("t3_src1_grant", req_ready, 2'b10);
        cyc();
        req_v = '0;
        #1;
        check_eq("t3_src1_flit", link_data, h_c[63:0]);
        cyc();
        set_src(0, h_a, zero_dat, 4'd1);
        set_src(1, h_b, zero_dat, 4'd1);
        req_v = 2'b11;
        #1;
        check_eq("t3_fair_grant", req_ready, 2'b01);
        cyc();

        // Back-to-back alternation 0,1,0,1 with no gap
        for (int p = 0; p < 4; p++) begin
            hx = (p % 2 == 1) ? h_b : h_a;
            #1;
            check_eq("b2b_flit0", link_data, hx[63:0]);
            check_eq("b2b_mid_ready", req_ready, 0);
            cyc();
            if (p == 3) req_v = '0;
            #1;
            exp_rdy = (p == 3) ? 2'b00 : ((p % 2 == 1) ? 2'b01 : 2'b10);
            check_eq("b2b_flit1", link_data, hx[127:64]);
            check_eq("b2b_handshake", req_ready, exp_rdy);
            cyc();
        end
        #1;
        check_eq("b2b_idle", link_v, 0);

        // Backpressure on a len=3 packet while source 1 waits
        set_src(0, h_d, dat, 4'd3);
        set_src(1, h_c, zero_dat, 4'd0);
        req_v = 2'b01;
        #1;
        check_eq("t5_grant", req_ready, 2'b01);
        cyc();
        req_v = 2'b10;
        c = 0;
        for (int k = 0; k < 7; k++) begin
            link_rdy = pat[k][0];
            #1;
            exp_flit = (c < 2) ? h_d[c*64 +: 64] : dat[(c-2)*64 +: 64];
            exp_rdy  = (pat[k] == 1 && c == 3) ? 2'b10 : 2'b00;
            check_eq("t5_flit", link_data, exp_flit);
            check_eq("t5_grant_hold", req_ready, exp_rdy);
            if (pat[k] == 1) c++;
            cyc();
        end
        req_v    = '0;
        link_rdy = 1'b1;
        #1;
        check_eq("t5_next_pkt", link_data, h_c[63:0]);
        cyc();
        check_eq("t5_idle", link_v, 0);

        // Reset in the middle of a 10-flit packet
        set_src(0, h_a, dat, 4'd9);
        req_v = 2'b01;
        #1;
        cyc();
        req_v = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("t6_pre_flit", link_data, (k < 2) ? h_a[k*64 +: 64] : dat[63:0]);
            cyc();
        end
        reset_n = 1'b0;
        #1;
        check_eq("t6_async_v", link_v, 0);
        check_eq("t6_async_busy", busy, 0);
        req_v = 2'b11;
        #1;
        check_eq("t6_rst_ready", req_ready, 0);
        req_v = '0;
        cyc();
        cyc();
        reset_n = 1'b1;
        #1;
        check_eq("t6_no_stale", link_v, 0);
        set_src(0, h_b, zero_dat, 4'd0);
        set_src(1, h_c, zero_dat, 4'd0);
        req_v = 2'b11;
        #1;
        check_eq("t6_grant_src0", req_ready, 2'b01);
        cyc();
        req_v = '0;
        #1;
        check_eq("t6_new_v", link_v, 1);
        check_eq("t6_new_flit", link_data, h_b[63:0]);
        cyc();
        check_eq("t6_end_idle", link_v, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
